// File: rtl/sample_sequencer.sv
// Audio sample sequencer: fetches 32-bit flash words, releases one 16-bit sample per tick,
// walks the sample region forwards or backwards with wrap-around, and reports a magnitude byte.
`timescale 1ns/1ps

module sample_sequencer #(
    parameter int unsigned       ADDR_W     = 23,
    parameter logic [ADDR_W-1:0] START_ADDR = 23'h000000,
    parameter logic [ADDR_W-1:0] END_ADDR   = 23'h07FFFF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              sample_tick,
    input  logic              play_en,
    input  logic              dir_rev,
    input  logic              restart,
    output logic              flash_req,
    output logic [ADDR_W-1:0] flash_addr,
    input  logic              flash_ack,
    input  logic [31:0]       flash_data,
    output logic [15:0]       audio_out,
    output logic              audio_valid,
    output logic [7:0]        music_data,
    output logic              read_interrupt,
    output logic              underrun,
    output logic [2:0]        state_dbg
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH    = 3'd1,
        SAMPLE_A = 3'd2,
        SAMPLE_B = 3'd3,
        DRAIN    = 3'd4
    } state_t;

    state_t            state;
    logic [31:0]       word;
    logic              word_rev;
    logic              drain_rev;

    logic              tick_live;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] restart_addr;
    logic [ADDR_W-1:0] drain_addr;
    logic [15:0]       rel_sample;
    logic [7:0]        rel_mag;

    // |s| with -32768 clamped to 32767, then bits [14:7] as the display byte.
    function automatic logic [7:0] mag_byte(input logic [15:0] s);
        logic [15:0] m;
        if (s == 16'h8000)
            m = 16'h7FFF;
        else if (s[15])
            m = ~s + 16'd1;
        else
            m = s;
        return m[14:7];
    endfunction

    always_comb begin
        tick_live    = sample_tick && play_en;
        restart_addr = dir_rev ? END_ADDR : START_ADDR;
        drain_addr   = drain_rev ? END_ADDR : START_ADDR;
        next_addr    = flash_addr;
        if (dir_rev)
            next_addr = (flash_addr == START_ADDR) ? END_ADDR : flash_addr - 1'b1;
        else
            next_addr = (flash_addr == END_ADDR) ? START_ADDR : flash_addr + 1'b1;
        rel_sample = '0;
        if (state == SAMPLE_A)
            rel_sample = word_rev ? word[31:16] : word[15:0];
        else
            rel_sample = word_rev ? word[15:0] : word[31:16];
        rel_mag = mag_byte(rel_sample);
    end

    // Flash handshake: flash_req is a level with flash_addr frozen until the one-cycle
    // flash_ack, which completes the transfer in that same cycle with flash_data valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            flash_addr     <= START_ADDR;
            flash_req      <= 1'b0;
            audio_out      <= '0;
            music_data     <= '0;
            audio_valid    <= 1'b0;
            read_interrupt <= 1'b0;
            underrun       <= 1'b0;
            word           <= '0;
            word_rev       <= 1'b0;
            drain_rev      <= 1'b0;
        end else begin
            audio_valid    <= 1'b0;
            read_interrupt <= 1'b0;
            if (restart) begin
                underrun <= 1'b0;
                word     <= '0;
                if (flash_req && !flash_ack) begin
                    state     <= DRAIN;
                    drain_rev <= dir_rev;
                end else begin
                    // An ack landing with restart closes the old request; re-raise next cycle.
                    flash_addr <= restart_addr;
                    flash_req  <= play_en && !flash_req;
                    state      <= play_en ? FETCH : IDLE;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (tick_live)
                            underrun <= 1'b1;
                        if (play_en) begin
                            state     <= FETCH;
                            flash_req <= 1'b1;
                        end
                    end
                    FETCH: begin
                        if (tick_live)
                            underrun <= 1'b1;
                        if (!flash_req) begin
                            flash_req <= 1'b1;
                        end else if (flash_ack) begin
                            word      <= flash_data;
                            word_rev  <= dir_rev;
                            flash_req <= 1'b0;
                            state     <= SAMPLE_A;
                        end
                    end
                    SAMPLE_A: begin
                        if (tick_live) begin
                            audio_out      <= rel_sample;
                            music_data     <= rel_mag;
                            audio_valid    <= 1'b1;
                            read_interrupt <= 1'b1;
                            state          <= SAMPLE_B;
                        end
                    end
                    SAMPLE_B: begin
                        if (tick_live) begin
                            audio_out      <= rel_sample;
                            music_data     <= rel_mag;
                            audio_valid    <= 1'b1;
                            read_interrupt <= 1'b1;
                            flash_addr     <= next_addr;
                            flash_req      <= 1'b1;
                            state          <= FETCH;
                        end
                    end
                    DRAIN: begin
                        if (tick_live)
                            underrun <= 1'b1;
                        if (flash_ack) begin
                            flash_addr <= drain_addr;
                            flash_req  <= 1'b0;
                            state      <= FETCH;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_sample_sequencer.sv
// Bench for sample_sequencer: scenario tasks drive a flash responder and sample ticks,
// expected samples go to a scoreboard queue that a negedge monitor drains.
`timescale 1ns/1ps

module tb_sample_sequencer;

    localparam int unsigned ADDR_W = 23;
    localparam logic [22:0] START    = 23'h000010;
    localparam logic [22:0] END_A    = 23'h00001F;
    localparam logic [22:0] START_P1 = START + 23'd1;
    localparam logic [22:0] END_M1   = END_A - 23'd1;

    logic        clk;
    logic        reset_n;
    logic        sample_tick;
    logic        play_en;
    logic        dir_rev;
    logic        restart;
    logic        flash_req;
    logic [22:0] flash_addr;
    logic        flash_ack;
    logic [31:0] flash_data;
    logic [15:0] audio_out;
    logic        audio_valid;
    logic [7:0]  music_data;
    logic        read_interrupt;
    logic        underrun;
    logic [2:0]  state_dbg;

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_exp;

    sample_sequencer #(
        .ADDR_W    (ADDR_W),
        .START_ADDR(START),
        .END_ADDR  (END_A)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .sample_tick   (sample_tick),
        .play_en       (play_en),
        .dir_rev       (dir_rev),
        .restart       (restart),
        .flash_req     (flash_req),
        .flash_addr    (flash_addr),
        .flash_ack     (flash_ack),
        .flash_data    (flash_data),
        .audio_out     (audio_out),
        .audio_valid   (audio_valid),
        .music_data    (music_data),
        .read_interrupt(read_interrupt),
        .underrun      (underrun),
        .state_dbg     (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_mag(input logic [15:0] s);
        int v;
        v = int'($signed(s));
        if (v < 0) v = -v;
        if (v > 32767) v = 32767;
        return v[14:7];
    endfunction

    // Scoreboard monitor: every released sample must match the head of the queue.
    always @(negedge clk) begin
        if (reset_n && (audio_valid || read_interrupt)) begin
            checks++;
            if (read_interrupt !== audio_valid) begin
                errors++;
                $display("FAIL irq_align: read_interrupt=%b audio_valid=%b, required equal", read_interrupt, audio_valid);
            end
            if (audio_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_sample: audio_out=%h music_data=%h, no sample expected", audio_out, music_data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if ({music_data, audio_out} !== mon_exp) begin
                        errors++;
                        $display("FAIL sample: got audio_out=%h music_data=%h, required audio_out=%h music_data=%h",
                                 audio_out, music_data, mon_exp[15:0], mon_exp[23:16]);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        cyc(1);
        restart = 1'b0;
    endtask

    task automatic do_fetch(input logic [22:0] exp_addr, input logic [31:0] data, input int delay);
        int   n = 0;
        logic stable = 1'b1;
        while (flash_req !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        checks++;
        if (flash_req !== 1'b1) begin
            errors++;
            $display("FAIL fetch_req_timeout: flash_req=%b after %0d cycles, required 1", flash_req, n);
        end
        checks++;
        if (flash_addr !== exp_addr) begin
            errors++;
            $display("FAIL fetch_addr: flash_addr=%h, required %h", flash_addr, exp_addr);
        end
        repeat (delay) begin
            cyc(1);
            if (flash_req !== 1'b1 || flash_addr !== exp_addr) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL fetch_hold: flash_req=%b flash_addr=%h, required 1 and %h", flash_req, flash_addr, exp_addr);
        end
        flash_ack  = 1'b1;
        flash_data = data;
        cyc(1);
        flash_ack  = 1'b0;
        flash_data = $urandom();
        checks++;
        if (flash_req !== 1'b0) begin
            errors++;
            $display("FAIL fetch_release: flash_req=%b after ack, required 0", flash_req);
        end
    endtask

    task automatic tick_expect(input logic [15:0] s);
        exp_q.push_back({exp_mag(s), s});
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        checks++;
        if (audio_valid !== 1'b1 || read_interrupt !== 1'b1) begin
            errors++;
            $display("FAIL tick_latency: audio_valid=%b read_interrupt=%b one cycle after tick, required 1 1", audio_valid, read_interrupt);
        end
        cyc(1);
        checks++;
        if (audio_valid !== 1'b0 || read_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL tick_width: audio_valid=%b read_interrupt=%b two cycles after tick, required 0 0", audio_valid, read_interrupt);
        end
    endtask

    task automatic tick_drop();
        sample_tick = 1'b1;
        cyc(1);
        sample_tick = 1'b0;
        checks++;
        if (audio_valid !== 1'b0) begin
            errors++;
            $display("FAIL tick_dropped: audio_valid=%b, required 0", audio_valid);
        end
    endtask

    task automatic check_next_fetch(input logic [22:0] exp_addr);
        checks++;
        if (flash_req !== 1'b1 || flash_addr !== exp_addr) begin
            errors++;
            $display("FAIL next_fetch: flash_req=%b flash_addr=%h, required 1 and %h", flash_req, flash_addr, exp_addr);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({flash_req, flash_addr, audio_out, music_data, audio_valid, read_interrupt, underrun, state_dbg} !==
            {1'b0, START, 16'h0, 8'h0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            errors++;
            $display("FAIL reset_state: req=%b addr=%h audio=%h music=%h valid=%b irq=%b underrun=%b state=%0d, required 0 %h 0 0 0 0 0 0",
                     flash_req, flash_addr, audio_out, music_data, audio_valid, read_interrupt, underrun, state_dbg, START);
        end
        reset_n = 1'b1;
        cyc(2);
        checks++;
        if (flash_req !== 1'b0 || state_dbg !== 3'd0) begin
            errors++;
            $display("FAIL idle_paused: flash_req=%b state=%0d with play_en=0, required 0 0", flash_req, state_dbg);
        end
    endtask

    task automatic test_forward();
        play_en = 1'b1;
        do_fetch(START, 32'h8000_1234, 2);
        cyc(2);
        tick_expect(16'h1234);
        checks++;
        if (music_data !== 8'h24) begin
            errors++;
            $display("FAIL fwd_music0: music_data=%h, required 24", music_data);
        end
        cyc(2);
        tick_expect(16'h8000);
        checks++;
        if (music_data !== 8'hFF || audio_out !== 16'h8000) begin
            errors++;
            $display("FAIL fwd_saturate: music_data=%h audio_out=%h, required FF 8000", music_data, audio_out);
        end
        check_next_fetch(START_P1);
    endtask

    task automatic test_reverse();
        dir_rev = 1'b1;
        pulse_restart();
        checks++;
        if (state_dbg !== 3'd4 || flash_req !== 1'b1 || flash_addr !== START_P1) begin
            errors++;
            $display("FAIL rev_drain: state=%0d req=%b addr=%h, required 4 1 %h", state_dbg, flash_req, flash_addr, START_P1);
        end
        do_fetch(START_P1, 32'hDEAD_BEEF, 1);
        do_fetch(END_A, 32'hFF00_0100, 0);
        cyc(1);
        tick_expect(16'hFF00);
        cyc(1);
        tick_expect(16'h0100);
        check_next_fetch(END_M1);
    endtask

    task automatic test_rev_wrap();
        dir_rev = 1'b0;
        pulse_restart();
        do_fetch(END_M1, 32'h1357_9BDF, 0);
        do_fetch(START, 32'h7FFF_FF80, 0);
        dir_rev = 1'b1;
        cyc(1);
        tick_expect(16'hFF80);
        cyc(1);
        tick_expect(16'h7FFF);
        check_next_fetch(END_A);
    endtask

    task automatic test_fwd_wrap();
        pulse_restart();
        do_fetch(END_A, 32'h2468_ACE0, 0);
        do_fetch(END_A, 32'h4000_C000, 0);
        dir_rev = 1'b0;
        cyc(1);
        tick_expect(16'h4000);
        cyc(1);
        tick_expect(16'hC000);
        check_next_fetch(START);
    endtask

    task automatic test_underrun();
        tick_drop();
        checks++;
        if (underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_set: underrun=%b, required 1", underrun);
        end
        cyc(3);
        do_fetch(START, 32'h1111_2222, 0);
        pulse_restart();
        checks++;
        if (underrun !== 1'b0 || flash_req !== 1'b1 || flash_addr !== START) begin
            errors++;
            $display("FAIL underrun_clear: underrun=%b req=%b addr=%h, required 0 1 %h", underrun, flash_req, flash_addr, START);
        end
        // ack and tick together: word is latched, tick is an underrun
        flash_ack   = 1'b1;
        flash_data  = 32'h0300_0400;
        sample_tick = 1'b1;
        cyc(1);
        flash_ack   = 1'b0;
        sample_tick = 1'b0;
        checks++;
        if (underrun !== 1'b1 || audio_valid !== 1'b0 || state_dbg !== 3'd2) begin
            errors++;
            $display("FAIL ack_tick: underrun=%b valid=%b state=%0d, required 1 0 2", underrun, audio_valid, state_dbg);
        end
        cyc(1);
        tick_expect(16'h0400);
        tick_expect(16'h0300);
        check_next_fetch(START_P1);
    endtask

    task automatic test_pause();
        pulse_restart();
        do_fetch(START_P1, 32'h0BAD_F00D, 0);
        do_fetch(START, 32'h9ABC_5678, 0);
        tick_expect(16'h5678);
        play_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1);
            tick_drop();
        end
        checks++;
        if (audio_out !== 16'h5678 || underrun !== 1'b0 || state_dbg !== 3'd3) begin
            errors++;
            $display("FAIL pause_hold: audio_out=%h underrun=%b state=%0d, required 5678 0 3", audio_out, underrun, state_dbg);
        end
        play_en = 1'b1;
        cyc(1);
        tick_expect(16'h9ABC);
        check_next_fetch(START_P1);
    endtask

    task automatic test_restart_mid_fetch();
        logic held = 1'b1;
        cyc(2);
        pulse_restart();
        for (int i = 0; i < 4; i++) begin
            if (flash_req !== 1'b1 || flash_addr !== START_P1) held = 1'b0;
            cyc(1);
        end
        checks++;
        if (!held) begin
            errors++;
            $display("FAIL drain_hold: flash_req=%b flash_addr=%h, required 1 %h", flash_req, flash_addr, START_P1);
        end
        do_fetch(START_P1, 32'h7777_7777, 0);
        do_fetch(START, 32'h0005_0006, 0);
        tick_expect(16'h0006);
        tick_expect(16'h0005);
        check_next_fetch(START_P1);
    endtask

    task automatic test_reset_mid_fetch();
        reset_n = 1'b0;
        #1;
        checks++;
        if (flash_req !== 1'b0 || state_dbg !== 3'd0 || flash_addr !== START) begin
            errors++;
            $display("FAIL reset_mid_fetch: req=%b state=%0d addr=%h, required 0 0 %h", flash_req, state_dbg, flash_addr, START);
        end
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    initial begin
        reset_n     = 1'b0;
        sample_tick = 1'b0;
        play_en     = 1'b0;
        dir_rev     = 1'b0;
        restart     = 1'b0;
        flash_ack   = 1'b0;
        flash_data  = '0;
        cyc(3);
        test_reset();
        test_forward();
        test_reverse();
        test_rev_wrap();
        test_fwd_wrap();
        test_underrun();
        test_pause();
        test_restart_mid_fetch();
        test_reset_mid_fetch();
        cyc(2);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d samples never released, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_sequencer.md
Name: sample_sequencer

Overview:
Schedules playback of 16-bit audio samples stored two per 32-bit flash word. It issues word fetches to the flash read FSM, releases one sample per sample-rate tick to the audio path, and advances the flash address with direction control and wrap-around. On every released sample it also emits a one-cycle read_interrupt pulse with an 8-bit magnitude byte on music_data, which feeds the PicoBlaze volume-display subsystem.

Parameters:
ADDR_W, 23, flash word-address width
START_ADDR, 23'h000000, first word of the sample region
END_ADDR, 23'h07FFFF, last word of the sample region (inclusive); END_ADDR > START_ADDR

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sample_tick  input  1  one-cycle strobe at sample rate, already synchronous to clk
play_en  input  1  1 = playback running, 0 = paused
dir_rev  input  1  1 = play backwards
restart  input  1  one-cycle strobe: jump to region start (fwd) or end (rev)
flash_req  output  1  word read request, level; held until flash_ack
flash_addr  output  ADDR_W  word address; stable while flash_req=1
flash_ack  input  1  one-cycle pulse; flash_data valid in the same cycle
flash_data  input  32  fetched word; [15:0] is the first sample, [31:16] the second
audio_out  output  16  current signed sample; held between updates
audio_valid  output  1  one-cycle pulse when audio_out updates
music_data  output  8  magnitude byte of the current sample
read_interrupt  output  1  one-cycle pulse, coincident with audio_valid
underrun  output  1  sticky: a tick arrived while no sample was ready

Behaviour:
- Reset, asynchronous: state IDLE; flash_addr=START_ADDR; flash_req=0; audio_out=0; music_data=0; audio_valid=0; read_interrupt=0; underrun=0; word register=0.
- States: IDLE, FETCH, SAMPLE_A, SAMPLE_B, DRAIN.
- IDLE:
  - If play_en=1, go to FETCH next cycle.
- FETCH:
  - flash_req=1 until flash_ack.
  - On flash_ack, latch flash_data and go to SAMPLE_A.
  - flash_addr must not change while flash_req=1.
- SAMPLE_A:
  - On sample_tick with play_en=1, release the first sample and go to SAMPLE_B.
  - First sample is [15:0] when forward, [31:16] when reverse.
- SAMPLE_B:
  - On sample_tick with play_en=1, release the other half.
  - Update the address, then go to FETCH.
- Sample release timing:
  - audio_out, music_data, audio_valid and read_interrupt are registered and appear the cycle after the tick, so latency is 1 clk.
  - audio_valid and read_interrupt are exactly 1 cycle wide.
- Address update:
  - Forward: addr+1. At END_ADDR, wrap to START_ADDR.
  - Reverse: addr-1. At START_ADDR, wrap to END_ADDR.
  - dir_rev is sampled only at the address update and at the half-select on SAMPLE_A entry. A change mid-word takes effect from the next word.
- music_data (s = 16-bit signed sample):
  - m = |s|; -32768 saturates to 32767.
  - music_data = m[14:7].
- Pause:
  - In SAMPLE_A or SAMPLE_B with play_en=0, ticks are ignored.
  - State, address and outputs hold; underrun is not set.
  - A FETCH in progress completes normally.
- Underrun:
  - A sample_tick while play_en=1 and state is FETCH, IDLE or DRAIN sets underrun=1.
  - That tick is dropped and does not produce a pulse.
- restart:
  - Load flash_addr with START_ADDR (dir_rev=0) or END_ADDR (dir_rev=1).
  - Clear underrun and discard the latched word.
  - If flash_req=1 when restart arrives, go to DRAIN and keep flash_req and the old address until flash_ack. The ack's data is discarded, then the address is loaded and the state goes to FETCH.
  - From any other state, go directly to FETCH (or IDLE if play_en=0).
- Simultaneous events:
  - restart beats sample_tick in the same cycle; no sample is released.
  - flash_ack together with sample_tick in FETCH: the word is latched and the tick counts as an underrun.
- Reset mid-fetch: flash_req drops immediately. The flash FSM must tolerate an abandoned request.

Test Plan:
- Forward playback: reset, play_en=1, ack word 32'h8000_1234, then two ticks -> audio_out 16'h1234 then 16'h8000; music_data 8'h24 then 8'hFF; two read_interrupt pulses, each 1 cycle wide and 1 cycle after its tick; next flash_addr=START_ADDR+1.
- Reverse and wrap: dir_rev=1, restart, ack word 32'hFF00_0100, two ticks -> flash_addr=END_ADDR for the fetch; audio_out 16'hFF00 then 16'h0100; next flash_addr=END_ADDR-1. Separately, with addr=START_ADDR in reverse, after two ticks -> flash_addr=END_ADDR.
- Forward wrap: preload to END_ADDR, consume two samples -> next flash_addr=START_ADDR.
- Underrun: delay flash_ack 5 cycles and tick during FETCH -> underrun=1, no audio_valid; next restart -> underrun=0.
- Pause: play_en=0 in SAMPLE_B with 3 ticks -> no pulses, audio_out held, underrun=0; play_en=1 then one tick -> second half released.
- Restart mid-fetch: restart while flash_req=1 -> flash_req held with the old addr until ack, ack data never appears on audio_out, then a new request goes out at START_ADDR.
